// File: rtl/im_loader.sv
// Byte-stream program loader: length-prefixed big-endian words into IM.
// Optional trailing XOR checksum byte when IM_LOADER_CHECKSUM_EN is defined.
module im_loader #(
  parameter int                    WORD_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [WORD_WIDTH-1:0] im_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           words_loaded
);

  localparam int NB = WORD_WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef IM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

`ifdef IM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t                  state_q, state_d;
  logic [15:0]             n_q, n_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [WORD_WIDTH-1:0]   word_q, word_d;
  logic [15:0]             wl_q, wl_d;
  logic                    in_ready_q, in_ready_d;
  logic                    im_we_q, im_we_d;
  logic [ADDR_WIDTH-1:0]   im_addr_q, im_addr_d;
  logic [WORD_WIDTH-1:0]   im_wdata_q, im_wdata_d;
  logic                    cpu_hold_q, cpu_hold_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    xfer;
  logic [15:0]             len;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]              xor_q, xor_d;
`endif

  assign xfer = in_valid && in_ready_q;
  assign len  = {n_q[15:8], in_data};

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    word_d     = word_q;
    wl_d       = wl_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          n_d     = '0;
          idx_d   = '0;
          wl_d    = '0;
`ifdef IM_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          n_d     = {in_data, n_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          n_d = len;
          if (len == 16'd0)
            state_d = S_FIN;
          else if (int'(len) > MAX_WORDS)
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          // first byte of the stream lands in the most significant lane
          word_d[8*(NB-1-int'(idx_q)) +: 8] = in_data;
`ifdef IM_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ in_data;
`endif
          if (idx_q == IW'(NB-1)) begin
            idx_d      = '0;
            state_d    = S_WRITE;
            im_we_d    = 1'b1;
            im_addr_d  = BASE_ADDR + (ADDR_WIDTH'(wl_q) << 2);
            im_wdata_d = word_d;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        wl_d    = wl_q + 16'd1;
        state_d = (wl_d == n_q) ? S_FIN : S_DATA;
      end
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer)
          state_d = (in_data == xor_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO)
              || (state_d == S_DATA)
`ifdef IM_LOADER_CHECKSUM_EN
              || (state_d == S_CHK)
`endif
              ;
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    cpu_hold_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      wl_q       <= '0;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= BASE_ADDR;
      im_wdata_q <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      wl_q       <= wl_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: normal, gapped, oversize, reset-abort,
// empty and max-length loads, plus checksum cases when enabled.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;
  int dbl   = 0;
  logic prev_we = 1'b0;
  logic [63:0] wq[$];
  logic [7:0]  s[$];

  im_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_we === 1'b1) wq.push_back({im_addr, im_wdata});
    if (prev_we && im_we) dbl++;
    prev_we = im_we;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wq_at(input int i);
    if (i < wq.size()) return wq[i];
    return 64'hxxxx_xxxx_xxxx_xxxx;
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    int c = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("ready_timeout", 64'(c < 50), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_all(input int gap);
    foreach (s[i]) send(s[i], gap);
  endtask

  task automatic add_chk();
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 2; i < s.size(); i++) x ^= s[i];
    s.push_back(x);
`endif
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int c = 0;
    while (!(done === 1'b1 || err === 1'b1) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("end_timeout", 64'(c < 100), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_hold",  64'(cpu_hold), 64'd1);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_we",    64'(im_we), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_err",   64'(err), 64'd0);
    chk("rst_wl",    64'(words_loaded), 64'd0);
    chk("rst_addr",  64'(im_addr), 64'd0);
    chk("rst_wdata", 64'(im_wdata), 64'd0);

    // two words, continuous valid
    wq.delete();
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
          8'hAC, 8'h09, 8'h00, 8'h04};
    add_chk();
    do_start();
    chk("ld1_ready", 64'(in_ready), 64'd1);
    send_all(0);
    wait_end();
    chk("ld1_n",    64'(wq.size()), 64'd2);
    chk("ld1_w0",   wq_at(0), {32'h0, 32'h20080005});
    chk("ld1_w1",   wq_at(1), {32'h4, 32'hAC090004});
    chk("ld1_done", 64'(done), 64'd1);
    chk("ld1_hold", 64'(cpu_hold), 64'd0);
    chk("ld1_wl",   64'(words_loaded), 64'd2);
    chk("ld1_rdy",  64'(in_ready), 64'd0);

    // same stream, valid toggling
    wq.delete();
    do_start();
    chk("ld2_hold_on", 64'(cpu_hold), 64'd1);
    chk("ld2_done_clr", 64'(done), 64'd0);
    send_all(1);
    wait_end();
    chk("ld2_n",    64'(wq.size()), 64'd2);
    chk("ld2_w0",   wq_at(0), {32'h0, 32'h20080005});
    chk("ld2_w1",   wq_at(1), {32'h4, 32'hAC090004});
    chk("ld2_done", 64'(done), 64'd1);
    chk("ld2_wl",   64'(words_loaded), 64'd2);

    // oversize header
    wq.delete();
    s = '{8'h04, 8'h01};
    do_start();
    send_all(0);
    wait_end();
    chk("big_err",  64'(err), 64'd1);
    chk("big_hold", 64'(cpu_hold), 64'd1);
    chk("big_done", 64'(done), 64'd0);
    chk("big_rdy",  64'(in_ready), 64'd0);
    chk("big_n",    64'(wq.size()), 64'd0);
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    add_chk();
    do_start();
    chk("rec_err_clr", 64'(err), 64'd0);
    send_all(0);
    wait_end();
    chk("rec_n",    64'(wq.size()), 64'd1);
    chk("rec_w0",   wq_at(0), {32'h0, 32'h12345678});
    chk("rec_done", 64'(done), 64'd1);
    chk("rec_wl",   64'(words_loaded), 64'd1);

    // reset mid-word
    wq.delete();
    s = '{8'h00, 8'h01, 8'hDE, 8'hAD};
    do_start();
    send_all(0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_hold", 64'(cpu_hold), 64'd1);
    chk("abort_rdy",  64'(in_ready), 64'd0);
    chk("abort_wl",   64'(words_loaded), 64'd0);
    chk("abort_n",    64'(wq.size()), 64'd0);
    s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    add_chk();
    do_start();
    send_all(0);
    wait_end();
    chk("dead_n",    64'(wq.size()), 64'd1);
    chk("dead_w0",   wq_at(0), {32'h0, 32'hDEADBEEF});
    chk("dead_done", 64'(done), 64'd1);

    // empty load
    wq.delete();
    s = '{8'h00, 8'h00};
    add_chk();
    do_start();
    send_all(0);
    wait_end();
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_hold", 64'(cpu_hold), 64'd0);
    chk("zero_wl",   64'(words_loaded), 64'd0);
    chk("zero_n",    64'(wq.size()), 64'd0);

    // exactly MAX_WORDS
    wq.delete();
    s = '{8'h04, 8'h00};
    for (int i = 0; i < 1024; i++) begin
      s.push_back(8'hA5);
      s.push_back(8'h5A);
      s.push_back(8'(i >> 8));
      s.push_back(8'(i));
    end
    add_chk();
    do_start();
    send_all(0);
    wait_end();
    chk("max_done", 64'(done), 64'd1);
    chk("max_n",    64'(wq.size()), 64'd1024);
    chk("max_wl",   64'(words_loaded), 64'd1024);
    chk("max_w1",   wq_at(1), {32'h4, 32'hA55A0001});
    chk("max_wl_last", wq_at(1023), {32'hFFC, 32'hA55A03FF});
    chk("we_single", 64'(dbl), 64'd0);

`ifdef IM_LOADER_CHECKSUM_EN
    wq.delete();
    s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    do_start();
    send_all(0);
    wait_end();
    chk("cs_ok_done", 64'(done), 64'd1);
    chk("cs_ok_w0",   wq_at(0), {32'h0, 32'h11223344});
    wq.delete();
    s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    do_start();
    send_all(0);
    wait_end();
    chk("cs_bad_err",  64'(err), 64'd1);
    chk("cs_bad_hold", 64'(cpu_hold), 64'd1);
    chk("cs_bad_n",    64'(wq.size()), 64'd1);
    chk("cs_bad_w0",   wq_at(0), {32'h0, 32'h11223344});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Byte-stream program loader that writes instruction memory. It is the writer side of the instruction-fetch path.
- Receives a length-prefixed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into IM at consecutive word addresses.
- Holds the CPU (`cpu_hold`) from reset until a load completes successfully.

Parameters:
- `WORD_WIDTH`, 32, width of assembled instruction word and IM write data.
- `ADDR_WIDTH`, 32, width of IM byte address.
- `BASE_ADDR`, 0, byte address of first word written. Matches the CPU reset PC.
- `MAX_WORDS`, 1024, largest legal word count in header.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  begin a load. Sampled only in IDLE, DONE, ERR.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts byte this cycle.
- `im_we`  out  1  IM write enable, one cycle per word.
- `im_addr`  out  `ADDR_WIDTH`  IM byte address, word aligned.
- `im_wdata`  out  `WORD_WIDTH`  IM write data.
- `cpu_hold`  out  1  stall CPU PC / suppress fetch.
- `done`  out  1  load completed, level.
- `err`  out  1  load aborted, level.
- `words_loaded`  out  16  words written in current/last load.

Behaviour:
- One clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state IDLE.
  - `in_ready`=0, `im_we`=0, `im_addr`=`BASE_ADDR`, `im_wdata`=0.
  - `cpu_hold`=1, `done`=0, `err`=0, `words_loaded`=0.
- Byte transfer: occurs at a rising edge with `in_valid`&&`in_ready`.
- `in_ready` is a registered function of state. It is 1 only in LEN_HI, LEN_LO, DATA, CHK.
- States:
  - IDLE: `cpu_hold`=1. `start` -> LEN_HI; clear `done`, `err`, `words_loaded`, word count N, byte index.
  - LEN_HI: accept byte -> N[15:8]; go LEN_LO.
  - LEN_LO: accept byte -> N[7:0]; then:
    - N==0 -> DONE (or CHK if feature on).
    - N>`MAX_WORDS` -> ERR.
    - else DATA.
  - DATA: accept 4 bytes. Byte 0 -> bits[31:24], byte 3 -> bits[7:0]. On the 4th accept go WRITE.
  - WRITE: `in_ready`=0. For exactly one cycle `im_we`=1, `im_addr`=`BASE_ADDR`+4*`words_loaded`, `im_wdata`=assembled word. Next cycle `words_loaded`++. If new count==N -> DONE (or CHK), else DATA.
  - DONE: `done`=1, `cpu_hold`=0, `in_ready`=0. `start` -> LEN_HI with `cpu_hold`=1 from the next cycle.
  - ERR: `err`=1, `cpu_hold`=1, `in_ready`=0. Only `start` or `rst` leaves.
- Latency: last byte of a word accepted at edge k -> `im_we` high in cycle k+1. Maximum throughput is one word per 5 cycles.
- Byte gaps: `in_valid` low mid-word stalls with the partial word retained. There is no timeout.
- `start` asserted while in LEN/DATA/WRITE/CHK is ignored.
- `rst` mid-load: immediate return to IDLE. The partial word is discarded and words already written are not undone. `cpu_hold`=1.
- `im_addr` arithmetic is modulo 2^`ADDR_WIDTH`.
- `words_loaded` is 16 bits. It never exceeds `MAX_WORDS`, so it never wraps.
- `im_we` never asserts outside WRITE.
- `cpu_hold` is a registered output with no combinational path from inputs.

Optional Feature:
- Macro: `IM_LOADER_CHECKSUM_EN`.
- Defined:
  - After the last word (or after header when N==0), state CHK accepts one byte.
  - Running XOR of all data bytes (header excluded) is compared with it.
  - Match -> DONE. Mismatch -> ERR; IM contents remain written.
- Undefined:
  - CHK state and XOR register are absent.
  - Completion goes directly to DONE; no trailing byte is consumed.

Test Plan:
- Reset then idle 10 cycles -> `cpu_hold`=1, `in_ready`=0, `im_we`=0, `done`=0.
- `start`; stream 00 02 20 08 00 05 AC 09 00 04 with `in_valid` constant -> writes 0x20080005 @0x0 then 0xAC090004 @0x4. Each `im_we` pulse is 1 cycle. `done`=1, `cpu_hold`=0, `words_loaded`=2.
- Same stream with `in_valid` toggled 1/0 every cycle -> identical writes and addresses; no extra `im_we`.
- Header 04 01 (N=1025 > `MAX_WORDS`) -> ERR, `err`=1, `cpu_hold`=1, no `im_we`. Then `start` + valid 1-word load -> DONE.
- `rst` after 2 data bytes of word 1 -> IDLE, no write. New load of 00 01 DE AD BE EF -> single write 0xDEADBEEF @0x0.
- With `IM_LOADER_CHECKSUM_EN`: 00 01 11 22 33 44 then 0x44 -> DONE. With trailing 0x45 -> ERR after the write of 0x11223344.
